prog_mem_loader: RTL and testbench

//  Write-side counterpart of the MCU program-memory fetch path. Receives a byte

---
 rtl/prog_mem_loader.sv | 106 ++++++++++
 tb/tb_prog_mem_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: packs a byte stream into 16-bit words and writes them to program memory, holding the CPU until a good load.
// Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module prog_mem_loader #(
  parameter int AW = 12,
  parameter logic [AW-1:0] LOAD_BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          pm_we,
  output logic [AW-1:0] pm_addr,
  output logic [15:0]   pm_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [2:0] IDLE = 3'd0, LEN_HI = 3'd1, LEN_LO = 3'd2, DATA_HI = 3'd3,
                         DATA_LO = 3'd4, WRITE = 3'd5, CSUM = 3'd6, FIN = 3'd7;
  logic [2:0]  state;
  logic [15:0] n, idx;
  logic [7:0]  hi_byte;
  logic        acc, len_bad;
  always_comb begin
    rx_ready = state == LEN_HI || state == LEN_LO || state == DATA_HI || state == DATA_LO || state == CSUM;
    acc = rx_valid && rx_ready;
    busy = state != IDLE;
    done = state == FIN;
    pm_we = state == WRITE;
    len_bad = {hi_byte, rx_data} == 16'd0 || 17'({hi_byte, rx_data}) > (17'(1) << AW);
  end
`ifdef CHECKSUM_EN
  logic [7:0] sum;
  always_ff @(posedge clk)
    if (rst || (state == IDLE && start)) sum <= '0;
    else if (acc) sum <= sum + rx_data;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pm_addr <= LOAD_BASE;
      pm_wdata <= '0;
      err <= 1'b0;
      cpu_hold <= 1'b1;
      n <= '0;
      idx <= '0;
      hi_byte <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LEN_HI;
          cpu_hold <= 1'b1;
          err <= 1'b0;
          idx <= '0;
        end
        LEN_HI: if (acc) begin
          hi_byte <= rx_data;
          state <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          n <= {hi_byte, rx_data};
          if (len_bad) begin
            err <= 1'b1;
            cpu_hold <= 1'b1;
            state <= FIN;
          end else state <= DATA_HI;
        end
        DATA_HI: if (acc) begin
          hi_byte <= rx_data;
          state <= DATA_LO;
        end
        DATA_LO: if (acc) begin
          pm_addr <= LOAD_BASE + idx[AW-1:0];
          pm_wdata <= {hi_byte, rx_data};
          state <= WRITE;
        end
        WRITE: begin
          idx <= idx + 16'd1;
          if (idx == n - 16'd1) begin
`ifdef CHECKSUM_EN
            state <= CSUM;
`else
            state <= FIN;
            cpu_hold <= err;
`endif
          end else state <= DATA_HI;
        end
        CSUM: begin
`ifdef CHECKSUM_EN
          if (acc) begin
            err <= (sum + rx_data) != 8'h00;
            cpu_hold <= (sum + rx_data) != 8'h00;
            state <= FIN;
          end
`else
          state <= FIN;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed tests of the program-memory loader, with a second instance at LOAD_BASE=FFF for address wrap.
module tb_prog_mem_loader;
  logic clk = 0, rst = 1, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, pm_we, cpu_hold, busy, done, err;
  logic [11:0] pm_addr;
  logic [15:0] pm_wdata;
  logic w_rx_ready, w_pm_we, w_cpu_hold, w_busy, w_done, w_err;
  logic [11:0] w_pm_addr;
  logic [15:0] w_pm_wdata;
  logic [11:0] la[$], wa[$];
  logic [15:0] ld[$], wd[$];
  logic [15:0] words[0:3];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  prog_mem_loader #(.AW(12), .LOAD_BASE(12'h000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err));

  prog_mem_loader #(.AW(12), .LOAD_BASE(12'hFFF)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(w_rx_ready), .pm_we(w_pm_we), .pm_addr(w_pm_addr), .pm_wdata(w_pm_wdata),
    .cpu_hold(w_cpu_hold), .busy(w_busy), .done(w_done), .err(w_err));

  always @(negedge clk) begin
    if (pm_we) begin la.push_back(pm_addr); ld.push_back(pm_wdata); end
    if (w_pm_we) begin wa.push_back(w_pm_addr); wd.push_back(w_pm_wdata); end
  end

  task automatic clear_logs();
    la.delete(); ld.delete(); wa.delete(); wd.delete();
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    for (int i = 0; i < 20 && !rx_ready; i++) @(negedge clk);
    if (!rx_ready) begin
      total++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
    end else @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_load(input logic [15:0] n, input int rnd, input logic [7:0] bad, input bit mid);
    logic [7:0] s;
    s = n[15:8] + n[7:0];
    pulse_start();
    send_byte(n[15:8], 0);
    if (mid) pulse_start();
    send_byte(n[7:0], 0);
    if (n != 0 && n <= 16'h1000) begin
      for (int i = 0; i < int'(n); i++) begin
        s = s + words[i][15:8] + words[i][7:0];
        send_byte(words[i][15:8], rnd ? $urandom_range(0, 3) : 0);
        send_byte(words[i][7:0], rnd ? $urandom_range(0, 3) : 0);
      end
`ifdef CHECKSUM_EN
      send_byte((8'h00 - s) ^ bad, 0);
`endif
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    total++;
    if (!done) $display("FAIL done_timeout: done=%b required 1", done); else passed++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    total++; if (cpu_hold !== 1'b1) $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b want 0", rx_ready); else passed++;
    total++; if (pm_we !== 1'b0) $display("FAIL reset_pm_we: got %b want 0", pm_we); else passed++;
    total++; if ({done, err} !== 2'b00) $display("FAIL reset_done_err: got %b want 00", {done, err}); else passed++;
    total++; if (w_pm_addr !== 12'hFFF) $display("FAIL reset_wrap_addr: got %h want fff", w_pm_addr); else passed++;
  endtask

  task automatic test_basic_and_wrap();
    clear_logs();
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_load(16'd2, 0, 8'h00, 0);
    wait_done();
    total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passed++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); else passed++;
    total++; if (la.size() != 2) $display("FAIL basic_write_count: got %0d want 2", la.size()); else passed++;
    if (la.size() == 2) begin
      total++; if (la[0] !== 12'h000 || ld[0] !== 16'h1234) $display("FAIL basic_w0: got @%h=%h want @000=1234", la[0], ld[0]); else passed++;
      total++; if (la[1] !== 12'h001 || ld[1] !== 16'hABCD) $display("FAIL basic_w1: got @%h=%h want @001=abcd", la[1], ld[1]); else passed++;
    end
    total++; if (wa.size() != 2) $display("FAIL wrap_write_count: got %0d want 2", wa.size()); else passed++;
    if (wa.size() == 2) begin
      total++; if (wa[0] !== 12'hFFF || wd[0] !== 16'h1234) $display("FAIL wrap_w0: got @%h=%h want @fff=1234", wa[0], wd[0]); else passed++;
      total++; if (wa[1] !== 12'h000 || wd[1] !== 16'hABCD) $display("FAIL wrap_w1: got @%h=%h want @000=abcd", wa[1], wd[1]); else passed++;
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle_after: busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if (pm_addr !== 12'h001 || pm_wdata !== 16'hABCD) $display("FAIL basic_hold: got @%h=%h want @001=abcd", pm_addr, pm_wdata); else passed++;
  endtask

  task automatic test_bad_len(input logic [15:0] n);
    clear_logs();
    send_load(n, 0, 8'h00, 0);
    wait_done();
    total++; if (err !== 1'b1) $display("FAIL badlen_%h_err: got %b want 1", n, err); else passed++;
    total++; if (cpu_hold !== 1'b1) $display("FAIL badlen_%h_hold: got %b want 1", n, cpu_hold); else passed++;
    total++; if (la.size() != 0) $display("FAIL badlen_%h_writes: got %0d want 0", n, la.size()); else passed++;
    @(negedge clk);
  endtask

  task automatic test_stall();
    clear_logs();
    words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h5A5A;
    send_load(16'd3, 1, 8'h00, 0);
    wait_done();
    total++; if (err !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL stall_status: err=%b hold=%b want 0 0", err, cpu_hold); else passed++;
    total++; if (la.size() != 3) $display("FAIL stall_write_count: got %0d want 3", la.size()); else passed++;
    if (la.size() == 3)
      for (int i = 0; i < 3; i++) begin
        total++;
        if (la[i] !== 12'(i) || ld[i] !== words[i]) $display("FAIL stall_w%0d: got @%h=%h want @%h=%h", i, la[i], ld[i], 12'(i), words[i]);
        else passed++;
      end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    clear_logs();
    words[0] = 16'h7788;
    send_load(16'd1, 0, 8'h00, 1);
    wait_done();
    total++; if (err !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL busystart_status: err=%b hold=%b want 0 0", err, cpu_hold); else passed++;
    total++;
    if (la.size() != 1 || ld[0] !== 16'h7788 || la[0] !== 12'h000) $display("FAIL busystart_write: count=%0d want 1 @000=7788", la.size());
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    repeat (2) @(negedge clk);
    pulse_start();
    total++; if (busy !== 1'b1 || rx_ready !== 1'b1) $display("FAIL abort_midstart: busy=%b rx_ready=%b want 1 1", busy, rx_ready); else passed++;
    total++; if (la.size() != 1 || ld[0] !== 16'h1122) $display("FAIL abort_first_write: count=%0d want 1 of 1122", la.size()); else passed++;
    rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    total++; if (busy !== 1'b0 || rx_ready !== 1'b0 || pm_we !== 1'b0) $display("FAIL abort_ctrl: busy=%b rdy=%b we=%b want 000", busy, rx_ready, pm_we); else passed++;
    total++; if (pm_addr !== 12'h000 || pm_wdata !== 16'h0000) $display("FAIL abort_regs: got @%h=%h want @000=0000", pm_addr, pm_wdata); else passed++;
    total++; if (cpu_hold !== 1'b1 || err !== 1'b0 || done !== 1'b0) $display("FAIL abort_status: hold=%b err=%b done=%b want 1 0 0", cpu_hold, err, done); else passed++;
    repeat (3) @(negedge clk);
    total++; if (la.size() != 1 || busy !== 1'b0) $display("FAIL abort_quiet: writes=%0d busy=%b want 1 0", la.size(), busy); else passed++;
  endtask

`ifdef CHECKSUM_EN
  task automatic test_bad_csum();
    clear_logs();
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_load(16'd2, 0, 8'h01, 0);
    wait_done();
    total++; if (err !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL badcsum: err=%b hold=%b want 1 1", err, cpu_hold); else passed++;
    total++; if (la.size() != 2) $display("FAIL badcsum_writes: got %0d want 2", la.size()); else passed++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and_wrap();
    test_bad_len(16'h0000);
    test_bad_len(16'h1001);
    test_stall();
    test_busy_start();
    test_abort();
`ifdef CHECKSUM_EN
    test_bad_csum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
